// File: rtl/rtmc_regs.sv
// RTMC register bank: decodes the SPI register bus into ID, CTRL, GPO, GPI level,
// sticky GPI rising-edge flags (W1C) and scratch registers, and drives a level irq.
module rtmc_regs #(
    parameter int          ADDR_W    = 4,
    parameter int          DATA_W    = 8,
    parameter int          GPI_W     = 14,
    parameter int          GPO_W     = 7,
    parameter int          N_SCRATCH = 4,
    parameter int unsigned ID_VALUE  = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] reg_addr,
    input  logic [DATA_W-1:0] reg_wdat,
    input  logic              reg_wr,
    input  logic              reg_rd,
    output logic [DATA_W-1:0] reg_rdat,
    output logic              reg_ack,
    input  logic [GPI_W-1:0]  gpi,
    output logic [GPO_W-1:0]  gpo,
    output logic              irq
);
    localparam int GPI_N  = (GPI_W + DATA_W - 1) / DATA_W;
    localparam int A_GPI  = 3;
    localparam int A_EDGE = 3 + GPI_N;
    localparam int A_SCR  = 3 + 2 * GPI_N;
    localparam logic [DATA_W-1:0] ID_D = DATA_W'(ID_VALUE);

    if (A_SCR + N_SCRATCH > 2 ** ADDR_W) begin : g_bad_map
        $error("rtmc_regs: register map does not fit in ADDR_W address bits");
    end
    if (GPO_W > DATA_W) begin : g_bad_gpo
        $error("rtmc_regs: GPO_W must not exceed DATA_W");
    end

    logic [DATA_W-1:0]       ctrl;
    logic [GPO_W-1:0]        gpo_r;
    logic [DATA_W-1:0]       scratch [N_SCRATCH];
    logic [GPI_W-1:0]        sync1, gpi_s, gpi_prev, edge_q;
    logic [GPI_W-1:0]        rise, edge_clr;
    logic [GPI_N*DATA_W-1:0] gpi_pad, edge_pad;
    logic [1:0]              warm_cnt;
    logic                    armed;
    logic [DATA_W-1:0]       rmux;

    // The counter masks the spurious rise seen while the synchroniser fills after reset.
    assign armed    = (warm_cnt == 2'd3);
    assign rise     = gpi_s & ~gpi_prev;
    assign gpi_pad  = (GPI_N*DATA_W)'(gpi_s);
    assign edge_pad = (GPI_N*DATA_W)'(edge_q);
    assign gpo      = gpo_r;

    always_comb begin
        edge_clr = '0;
        for (int b = 0; b < GPI_W; b++) begin
            if (reg_wr && reg_addr == ADDR_W'(A_EDGE + b / DATA_W) && reg_wdat[b % DATA_W])
                edge_clr[b] = 1'b1;
        end
    end

    always_comb begin
        rmux = '0;
        if (reg_addr == ADDR_W'(0)) rmux = ID_D;
        if (reg_addr == ADDR_W'(1)) rmux = ctrl;
        if (reg_addr == ADDR_W'(2)) rmux = DATA_W'(gpo_r);
        for (int i = 0; i < GPI_N; i++) begin
            if (reg_addr == ADDR_W'(A_GPI + i))  rmux = gpi_pad[i*DATA_W +: DATA_W];
            if (reg_addr == ADDR_W'(A_EDGE + i)) rmux = edge_pad[i*DATA_W +: DATA_W];
        end
        for (int i = 0; i < N_SCRATCH; i++) begin
            if (reg_addr == ADDR_W'(A_SCR + i)) rmux = scratch[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            reg_rdat <= '0;
            reg_ack  <= 1'b0;
            ctrl     <= '0;
            gpo_r    <= '0;
            for (int i = 0; i < N_SCRATCH; i++) scratch[i] <= '0;
            sync1    <= '0;
            gpi_s    <= '0;
            gpi_prev <= '0;
            edge_q   <= '0;
            warm_cnt <= '0;
            irq      <= 1'b0;
        end else begin
            reg_ack <= reg_wr | reg_rd;
            // Read data is taken from the mux before this cycle's write lands.
            if (reg_rd) reg_rdat <= rmux;
            if (reg_wr && reg_addr == ADDR_W'(1)) ctrl  <= reg_wdat;
            if (reg_wr && reg_addr == ADDR_W'(2)) gpo_r <= reg_wdat[GPO_W-1:0];
            for (int i = 0; i < N_SCRATCH; i++) begin
                if (reg_wr && reg_addr == ADDR_W'(A_SCR + i)) scratch[i] <= reg_wdat;
            end
            sync1    <= gpi;
            gpi_s    <= sync1;
            gpi_prev <= gpi_s;
            if (!armed) warm_cnt <= warm_cnt + 2'd1;
            // Set has priority over a coincident W1C clear.
            edge_q   <= (edge_q & ~edge_clr) | (rise & {GPI_W{armed}});
            irq      <= ctrl[0] & (|edge_q);
        end
    end
endmodule

// File: tb/tb_rtmc_regs.sv
// Directed self-checking bench for rtmc_regs with the default parameter set.
module tb_rtmc_regs;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  reg_addr = '0;
    logic [7:0]  reg_wdat = '0;
    logic        reg_wr = 1'b0;
    logic        reg_rd = 1'b0;
    logic [7:0]  reg_rdat;
    logic        reg_ack;
    logic [13:0] gpi = 14'h3FFF;
    logic [6:0]  gpo;
    logic        irq;

    int checks = 0;
    int fails  = 0;

    rtmc_regs dut (
        .clk(clk), .rst(rst), .reg_addr(reg_addr), .reg_wdat(reg_wdat),
        .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_rdat(reg_rdat), .reg_ack(reg_ack),
        .gpi(gpi), .gpo(gpo), .irq(irq)
    );

    always #5 clk = ~clk;

    // Strobe for one cycle; returns at the negedge of the cycle after the strobe.
    task automatic bus(input logic w, input logic r, input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        reg_wr = w; reg_rd = r; reg_addr = a; reg_wdat = d;
        @(negedge clk);
        reg_wr = 1'b0; reg_rd = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (reg_rdat !== 8'h00) begin fails++; $display("FAIL reset_rdat: got %h, expected 00", reg_rdat); end
        checks++; if (reg_ack !== 1'b0) begin fails++; $display("FAIL reset_ack: got %b, expected 0", reg_ack); end
        checks++; if (gpo !== 7'h00) begin fails++; $display("FAIL reset_gpo: got %h, expected 00", gpo); end
        checks++; if (irq !== 1'b0) begin fails++; $display("FAIL reset_irq: got %b, expected 0", irq); end
        rst = 1'b0;
    endtask

    task automatic test_id();
        bus(1'b0, 1'b1, 4'd0, 8'h00);
        checks++; if (reg_ack !== 1'b1) begin fails++; $display("FAIL id_ack: got %b, expected 1", reg_ack); end
        checks++; if (reg_rdat !== 8'hA5) begin fails++; $display("FAIL id_rdat: got %h, expected a5", reg_rdat); end
        @(negedge clk);
        checks++; if (reg_ack !== 1'b0) begin fails++; $display("FAIL id_ack_pulse: got %b, expected 0", reg_ack); end
        bus(1'b0, 1'b1, 4'd15, 8'h00);
        checks++; if (reg_ack !== 1'b1) begin fails++; $display("FAIL unmapped_ack: got %b, expected 1", reg_ack); end
        checks++; if (reg_rdat !== 8'h00) begin fails++; $display("FAIL unmapped_rdat: got %h, expected 00", reg_rdat); end
    endtask

    task automatic test_gpo();
        bus(1'b1, 1'b0, 4'd2, 8'h7F);
        checks++; if (gpo !== 7'h7F) begin fails++; $display("FAIL gpo_out: got %h, expected 7f", gpo); end
        bus(1'b0, 1'b1, 4'd2, 8'h00);
        checks++; if (reg_rdat !== 8'h7F) begin fails++; $display("FAIL gpo_read: got %h, expected 7f", reg_rdat); end
        bus(1'b1, 1'b0, 4'd0, 8'hFF);
        bus(1'b0, 1'b1, 4'd0, 8'h00);
        checks++; if (reg_rdat !== 8'hA5) begin fails++; $display("FAIL id_ro: got %h, expected a5", reg_rdat); end
    endtask

    task automatic test_gpi_edge();
        bus(1'b0, 1'b1, 4'd3, 8'h00);
        checks++; if (reg_rdat !== 8'hFF) begin fails++; $display("FAIL gpi_lo: got %h, expected ff", reg_rdat); end
        bus(1'b0, 1'b1, 4'd4, 8'h00);
        checks++; if (reg_rdat !== 8'h3F) begin fails++; $display("FAIL gpi_hi: got %h, expected 3f", reg_rdat); end
        bus(1'b0, 1'b1, 4'd5, 8'h00);
        checks++; if (reg_rdat !== 8'h00) begin fails++; $display("FAIL warmup_edge_lo: got %h, expected 00", reg_rdat); end
        bus(1'b0, 1'b1, 4'd6, 8'h00);
        checks++; if (reg_rdat !== 8'h00) begin fails++; $display("FAIL warmup_edge_hi: got %h, expected 00", reg_rdat); end
        @(negedge clk); gpi[9] = 1'b0;
        repeat (4) @(negedge clk);
        bus(1'b0, 1'b1, 4'd4, 8'h00);
        checks++; if (reg_rdat !== 8'h3D) begin fails++; $display("FAIL gpi_drop: got %h, expected 3d", reg_rdat); end
        gpi[9] = 1'b1;
        repeat (5) @(negedge clk);
        bus(1'b0, 1'b1, 4'd6, 8'h00);
        checks++; if (reg_rdat !== 8'h02) begin fails++; $display("FAIL edge9_hi: got %h, expected 02", reg_rdat); end
        bus(1'b0, 1'b1, 4'd5, 8'h00);
        checks++; if (reg_rdat !== 8'h00) begin fails++; $display("FAIL edge9_lo: got %h, expected 00", reg_rdat); end
    endtask

    task automatic test_irq();
        bus(1'b1, 1'b0, 4'd6, 8'h02);
        gpi[0] = 1'b0;
        bus(1'b1, 1'b0, 4'd1, 8'h01);
        repeat (4) @(negedge clk);
        checks++; if (irq !== 1'b0) begin fails++; $display("FAIL irq_idle: got %b, expected 0", irq); end
        gpi[0] = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (irq !== 1'b0) begin fails++; $display("FAIL irq_early: got %b, expected 0", irq); end
        @(negedge clk);
        checks++; if (irq !== 1'b1) begin fails++; $display("FAIL irq_rise: got %b, expected 1", irq); end
        bus(1'b1, 1'b0, 4'd5, 8'h01);
        @(negedge clk);
        checks++; if (irq !== 1'b0) begin fails++; $display("FAIL irq_clear: got %b, expected 0", irq); end
        bus(1'b0, 1'b1, 4'd5, 8'h00);
        checks++; if (reg_rdat !== 8'h00) begin fails++; $display("FAIL edge_w1c: got %h, expected 00", reg_rdat); end
        gpi[0] = 1'b0;
        repeat (4) @(negedge clk);
        gpi[0] = 1'b1;
        @(negedge clk);
        bus(1'b1, 1'b0, 4'd5, 8'h01);
        bus(1'b0, 1'b1, 4'd5, 8'h00);
        checks++; if (reg_rdat !== 8'h01) begin fails++; $display("FAIL set_beats_clear: got %h, expected 01", reg_rdat); end
        checks++; if (irq !== 1'b1) begin fails++; $display("FAIL irq_after_race: got %b, expected 1", irq); end
    endtask

    task automatic test_rd_wr_same();
        bus(1'b1, 1'b0, 4'd7, 8'h33);
        bus(1'b1, 1'b1, 4'd7, 8'h5A);
        checks++; if (reg_ack !== 1'b1) begin fails++; $display("FAIL rw_ack: got %b, expected 1", reg_ack); end
        checks++; if (reg_rdat !== 8'h33) begin fails++; $display("FAIL rw_old: got %h, expected 33", reg_rdat); end
        @(negedge clk);
        checks++; if (reg_ack !== 1'b0) begin fails++; $display("FAIL rw_single_ack: got %b, expected 0", reg_ack); end
        bus(1'b0, 1'b1, 4'd7, 8'h00);
        checks++; if (reg_rdat !== 8'h5A) begin fails++; $display("FAIL rw_new: got %h, expected 5a", reg_rdat); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        reg_wr = 1'b1; reg_rd = 1'b0; reg_addr = 4'd8; reg_wdat = 8'hC3;
        @(negedge clk);
        checks++; if (reg_ack !== 1'b1) begin fails++; $display("FAIL b2b_ack1: got %b, expected 1", reg_ack); end
        reg_wr = 1'b0; reg_rd = 1'b1;
        @(negedge clk);
        reg_rd = 1'b0;
        checks++; if (reg_ack !== 1'b1) begin fails++; $display("FAIL b2b_ack2: got %b, expected 1", reg_ack); end
        checks++; if (reg_rdat !== 8'hC3) begin fails++; $display("FAIL b2b_rdat: got %h, expected c3", reg_rdat); end
        @(negedge clk);
        checks++; if (reg_ack !== 1'b0) begin fails++; $display("FAIL b2b_ack_end: got %b, expected 0", reg_ack); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        rst = 1'b1; reg_rd = 1'b1; reg_addr = 4'd0;
        @(negedge clk);
        reg_rd = 1'b0;
        checks++; if (reg_ack !== 1'b0) begin fails++; $display("FAIL rst_mid_ack: got %b, expected 0", reg_ack); end
        checks++; if (reg_rdat !== 8'h00) begin fails++; $display("FAIL rst_mid_rdat: got %h, expected 00", reg_rdat); end
        checks++; if (gpo !== 7'h00) begin fails++; $display("FAIL rst_mid_gpo: got %h, expected 00", gpo); end
        checks++; if (irq !== 1'b0) begin fails++; $display("FAIL rst_mid_irq: got %b, expected 0", irq); end
        rst = 1'b0;
        bus(1'b0, 1'b1, 4'd8, 8'h00);
        checks++; if (reg_rdat !== 8'h00) begin fails++; $display("FAIL rst_mid_scratch: got %h, expected 00", reg_rdat); end
    endtask

    initial begin
        test_reset();
        test_id();
        test_gpo();
        test_gpi_edge();
        test_irq();
        test_rd_wr_same();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
